exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 freeze  input  1  memory-stage stall; holds all state.
REQ-004 wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  input  1 each  control from ID/EX register.
REQ-005 exe_cmd_in  input  4  ALU operation; dest_in  input  4  destination register.
REQ-006 shift_operand_in  input  12; signed_imm_24_in  input  24; pc_in  input  32; val_rn_in, val_rm_in  input  32 each.
REQ-007 sel_src1, sel_src2  input  2 each; mem_fwd_val, wb_fwd_val  input  32 each; present only with FORWARDING_EN.
REQ-008 wb_en, mem_r_en, mem_w_en  output  1 each; alu_res, val_rm  output  32 each; dest  output  4; EX/MEM registered.
REQ-009 branch_taken  output  1; branch_addr  output  32; combinational.
REQ-010 status  output  4  registered flags {N,Z,C,V}, fed back to ID for condition check.

Function
REQ-011 Op2 generation: imm_in=1 -> {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
REQ-012 Op2 generation: imm_in=0 and (mem_r_en_in|mem_w_en_in) -> zero-extended shift_operand[11:0].
REQ-013 Op2 generation otherwise: op B shifted by shift_operand[11:7]; type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; amount 0 passes through.
REQ-014 exe_cmd: 0001 MOV op2; 1001 MVN ~op2; 0010 ADD; 0011 ADC A+op2+C; 0100 SUB; 0101 SBC A-op2-!C; 0110 AND; 0111 ORR; 1000 EOR; others -> result 0, flags unchanged.
REQ-015 Flags: N=result[31]; Z=(result==0); C=carry-out of 33-bit add, or NOT borrow for subtract; V=signed overflow; logical ops and MOV/MVN keep previous C and V.
REQ-016 status updates on the clock edge only when s_in=1 and freeze=0; otherwise it holds.
REQ-017 EX/MEM register loads {wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest} from current inputs each edge when freeze=0; holds all fields when freeze=1.
REQ-018 Latency: one cycle from inputs to registered outputs; the status value is visible the cycle after the S instruction.
REQ-019 branch_taken=b_in; branch_addr = pc_in + (sign-extended signed_imm_24_in << 2), 32-bit wrap-around.
REQ-020 Operand B for shift and the registered val_rm use the forwarded Rm value when FORWARDING_EN is defined.

Reset
REQ-021 rst=1 clears every EX/MEM output and status to 0 immediately, independent of clk.
REQ-022 Reset takes priority over freeze; an operation in flight during reset is discarded.

Configuration
REQ-023 Macro EXE_FORWARDING_EN defined: operand A selected by sel_src1 and operand Rm by sel_src2; 00 ID value, 01 mem_fwd_val, 10 wb_fwd_val, 11 ID value.
REQ-024 Macro undefined: forwarding ports absent; val_rn_in and val_rm_in used directly.

Structure
REQ-025 Shared package exe_pkg holds the EXE_CMD encodings, shift-type codes, forwarding-select codes and flag bit indices.
REQ-026 Op2 generation is a sub-module val2_gen (combinational); the ALU, flags, status register and EX/MEM register live in exe_stage.

Verification
REQ-027 ADD: Rn=0x7FFFFFFF, imm=1, shift_operand=0x001, S=1 -> alu_res 0x80000000; status N=1 Z=0 C=0 V=1 next cycle.
REQ-028 SUB/CMP: Rn=5, Rm=5, LSL #0, S=1 -> result 0; Z=1 C=1; a following ADC of 1+1 gives 3.
REQ-029 Rotated immediate: shift_operand=0x4FF (imm=1) -> op2 0xFF000000; ASR of Rm=0x80000000 by 4 -> 0xF8000000.
REQ-030 Freeze held 3 cycles with changing inputs -> registered outputs and status unchanged; the next new values load on the first edge after freeze drops.
REQ-031 Branch: pc_in=0x100, imm24=0xFFFFFE -> branch_addr 0x0F8, branch_taken=1; rst asserted mid-stream -> all outputs 0 without a clock edge.
REQ-032 With EXE_FORWARDING_EN: sel_src1=01, mem_fwd_val=0x10, Rn=0 -> ADD with op2 1 gives 0x11.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command encodings,
// shift-type codes, forwarding-select codes, flag bit positions and
// a rotate helper used by operand-2 generation.
package exe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_ID     = 2'b00;
  localparam logic [1:0] FWD_MEM    = 2'b01;
  localparam logic [1:0] FWD_WB     = 2'b10;
  localparam logic [1:0] FWD_ID_ALT = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate a 32-bit word right by 0..31 positions.
  function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {val, val} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Execute-stage bus: ID/EX inputs, EX/MEM results and branch outputs.
// Forwarding signals exist only when EXE_FORWARDING_EN is defined.
interface exe_stage_if;
  logic        freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
`ifdef EXE_FORWARDING_EN
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
`endif
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;

  modport master (
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exe_cmd_in, dest_in, shift_operand_in, signed_imm_24_in,
           pc_in, val_rn_in, val_rm_in,
    input  wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest,
           branch_taken, branch_addr, status
`ifdef EXE_FORWARDING_EN
    , output sel_src1, sel_src2, mem_fwd_val, wb_fwd_val
`endif
  );

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exe_cmd_in, dest_in, shift_operand_in, signed_imm_24_in,
           pc_in, val_rn_in, val_rm_in,
    output wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest,
           branch_taken, branch_addr, status
`ifdef EXE_FORWARDING_EN
    , input sel_src1, sel_src2, mem_fwd_val, wb_fwd_val
`endif
  );
endinterface

// File: rtl/val2_gen.sv
// Operand-2 generator: rotated 8-bit immediate, 12-bit memory offset,
// or shifted register (LSL/LSR/ASR/ROR by a 5-bit amount).
module val2_gen
  import exe_pkg::*;
(
  input  logic        imm,
  input  logic        mem_en,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_rm,
  output logic [31:0] val2
);

  logic [4:0] amt_s;
  assign amt_s = shift_operand[11:7];

  // Select the operand-2 form; a zero shift amount passes Rm unchanged.
  always_comb begin
    val2 = 32'd0;
    if (imm) begin
      val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_en) begin
      val2 = {20'd0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        SHIFT_LSL: val2 = val_rm << amt_s;
        SHIFT_LSR: val2 = val_rm >> amt_s;
        SHIFT_ASR: val2 = 32'($signed(val_rm) >>> amt_s);
        SHIFT_ROR: val2 = ror32(val_rm, amt_s);
        default:   val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, {N,Z,C,V} status register, EX/MEM pipeline register
// and branch target calculation. Optional operand forwarding is enabled by
// defining EXE_FORWARDING_EN.
module exe_stage
  import exe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  exe_stage_if.slave bus
);

  logic [31:0] op_a_s, op_rm_s, val2_s, alu_res_s;
  logic [32:0] sum_s;
  logic        carry_s, ovf_s, valid_op_s;
  logic [3:0]  next_status_s;

  logic        wb_en_r, mem_r_en_r, mem_w_en_r;
  logic [31:0] alu_res_r, val_rm_r;
  logic [3:0]  dest_r, status_r;

`ifdef EXE_FORWARDING_EN
  // Pick operand A and Rm from the ID value or the later-stage results.
  always_comb begin
    op_a_s  = bus.val_rn_in;
    op_rm_s = bus.val_rm_in;
    case (bus.sel_src1)
      FWD_MEM: op_a_s = bus.mem_fwd_val;
      FWD_WB:  op_a_s = bus.wb_fwd_val;
      default: op_a_s = bus.val_rn_in;
    endcase
    case (bus.sel_src2)
      FWD_MEM: op_rm_s = bus.mem_fwd_val;
      FWD_WB:  op_rm_s = bus.wb_fwd_val;
      default: op_rm_s = bus.val_rm_in;
    endcase
  end
`else
  assign op_a_s  = bus.val_rn_in;
  assign op_rm_s = bus.val_rm_in;
`endif

  val2_gen u_val2_gen (
    .imm           (bus.imm_in),
    .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
    .shift_operand (bus.shift_operand_in),
    .val_rm        (op_rm_s),
    .val2          (val2_s)
  );

  // ALU: result plus carry/overflow; logical ops keep the previous C and V.
  always_comb begin
    sum_s      = 33'd0;
    alu_res_s  = 32'd0;
    carry_s    = status_r[FLAG_C];
    ovf_s      = status_r[FLAG_V];
    valid_op_s = 1'b1;
    case (bus.exe_cmd_in)
      EXE_MOV: alu_res_s = val2_s;
      EXE_MVN: alu_res_s = ~val2_s;
      EXE_ADD, EXE_ADC: begin
        sum_s = {1'b0, op_a_s} + {1'b0, val2_s}
              + ((bus.exe_cmd_in == EXE_ADC) ? {32'd0, status_r[FLAG_C]} : 33'd0);
        alu_res_s = sum_s[31:0];
        carry_s   = sum_s[32];
        ovf_s     = (op_a_s[31] == val2_s[31]) && (alu_res_s[31] != op_a_s[31]);
      end
      EXE_SUB, EXE_SBC: begin
        sum_s = {1'b0, op_a_s} + {1'b0, ~val2_s}
              + ((bus.exe_cmd_in == EXE_SBC) ? {32'd0, status_r[FLAG_C]} : 33'd1);
        alu_res_s = sum_s[31:0];
        carry_s   = sum_s[32];
        ovf_s     = (op_a_s[31] != val2_s[31]) && (alu_res_s[31] != op_a_s[31]);
      end
      EXE_AND: alu_res_s = op_a_s & val2_s;
      EXE_ORR: alu_res_s = op_a_s | val2_s;
      EXE_EOR: alu_res_s = op_a_s ^ val2_s;
      default: valid_op_s = 1'b0;
    endcase
  end

  assign next_status_s = {alu_res_s[31], (alu_res_s == 32'd0), carry_s, ovf_s};

  // Status register: updates only for flag-setting valid ops when not frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_r <= 4'd0;
    end else if (!bus.freeze && bus.s_in && valid_op_s) begin
      status_r <= next_status_s;
    end else begin
      status_r <= status_r;
    end
  end

  // EX/MEM pipeline register: loads every unfrozen edge, holds under freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_r    <= 1'b0;
      mem_r_en_r <= 1'b0;
      mem_w_en_r <= 1'b0;
      alu_res_r  <= 32'd0;
      val_rm_r   <= 32'd0;
      dest_r     <= 4'd0;
    end else if (!bus.freeze) begin
      wb_en_r    <= bus.wb_en_in;
      mem_r_en_r <= bus.mem_r_en_in;
      mem_w_en_r <= bus.mem_w_en_in;
      alu_res_r  <= alu_res_s;
      val_rm_r   <= op_rm_s;
      dest_r     <= bus.dest_in;
    end else begin
      wb_en_r    <= wb_en_r;
      mem_r_en_r <= mem_r_en_r;
      mem_w_en_r <= mem_w_en_r;
      alu_res_r  <= alu_res_r;
      val_rm_r   <= val_rm_r;
      dest_r     <= dest_r;
    end
  end

  assign bus.wb_en    = wb_en_r;
  assign bus.mem_r_en = mem_r_en_r;
  assign bus.mem_w_en = mem_w_en_r;
  assign bus.alu_res  = alu_res_r;
  assign bus.val_rm   = val_rm_r;
  assign bus.dest     = dest_r;
  assign bus.status   = status_r;

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed, table-driven bench for exe_stage plus hand-written sequences
// for freeze, branch target and asynchronous reset.
module tb_exe_stage;
  import exe_pkg::*;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, wb, mr, mw;
    logic [11:0] so;
    logic [31:0] rn, rm;
    logic [3:0]  dest;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[17];

  exe_stage_if bus();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.exe_cmd_in       = v.cmd;
    bus.s_in             = v.s;
    bus.imm_in           = v.imm;
    bus.wb_en_in         = v.wb;
    bus.mem_r_en_in      = v.mr;
    bus.mem_w_en_in      = v.mw;
    bus.shift_operand_in = v.so;
    bus.val_rn_in        = v.rn;
    bus.val_rm_in        = v.rm;
    bus.dest_in          = v.dest;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_alu"},  bus.alu_res, 32'd0);
    chk({tag, "_rm"},   bus.val_rm, 32'd0);
    chk({tag, "_dest"}, {28'd0, bus.dest}, 32'd0);
    chk({tag, "_ctl"},  {29'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'd0);
    chk({tag, "_st"},   {28'd0, bus.status}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{EXE_MOV, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h4FF, 32'h0,        32'h0,        4'h1, 32'hFF000000, 4'b0000};
    vecs[1]  = '{EXE_MOV, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h240, 32'h0,        32'h80000000, 4'h2, 32'hF8000000, 4'b1000};
    vecs[2]  = '{EXE_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'h7FFFFFFF, 32'h0,        4'h3, 32'h80000000, 4'b1001};
    vecs[3]  = '{EXE_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h5,        32'h5,        4'h4, 32'h0,        4'b0110};
    vecs[4]  = '{EXE_ADC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'h1,        32'h0,        4'h5, 32'h3,        4'b0000};
    vecs[5]  = '{EXE_SBC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h003, 32'hA,        32'h0,        4'h6, 32'h6,        4'b0010};
    vecs[6]  = '{EXE_MVN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0,        32'h0,        4'h7, 32'hFFFFFFFF, 4'b1010};
    vecs[7]  = '{EXE_AND, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 32'hF0F0F0F0, 32'h0,        4'h8, 32'h000000F0, 4'b0010};
    vecs[8]  = '{EXE_ORR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h220, 32'h0F000000, 32'h000000F0, 4'h9, 32'h0F00000F, 4'b0010};
    vecs[9]  = '{EXE_EOR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA, 32'h0,        4'b0110};
    vecs[10] = '{4'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h1,        32'h1,        4'hB, 32'h0,        4'b0110};
    vecs[11] = '{EXE_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFFF, 32'h1000,     32'hDEADBEEF, 4'hC, 32'h1FFF,     4'b0110};
    vecs[12] = '{EXE_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h260, 32'h0,        32'h000000F1, 4'hD, 32'h1000000F, 4'b0110};
    vecs[13] = '{EXE_MOV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h400, 32'h0,        32'h12345678, 4'hE, 32'h34567800, 4'b0110};
    vecs[14] = '{EXE_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'hFFFFFFFF, 32'h0,        4'hF, 32'h0,        4'b0110};
    vecs[15] = '{EXE_SUB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'h80000000, 32'h0,        4'h1, 32'h7FFFFFFF, 4'b0011};
    vecs[16] = '{EXE_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h010, 32'h2000,     32'h55,       4'h2, 32'h2010,     4'b0011};

    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.b_in = 1'b0;
    bus.pc_in = 32'd0;
    bus.signed_imm_24_in = 24'd0;
`ifdef EXE_FORWARDING_EN
    bus.sel_src1 = FWD_ID;
    bus.sel_src2 = FWD_ID;
    bus.mem_fwd_val = 32'd0;
    bus.wb_fwd_val = 32'd0;
`endif
    drive(vecs[2]);
    #1;
    chk_outs_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: one instruction per cycle, results visible after the next edge.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_res", i), bus.alu_res, vecs[i].res);
      chk($sformatf("v%0d_st", i), {28'd0, bus.status}, {28'd0, vecs[i].st});
      chk($sformatf("v%0d_dest", i), {28'd0, bus.dest}, {28'd0, vecs[i].dest});
      chk($sformatf("v%0d_rm", i), bus.val_rm, vecs[i].rm);
      chk($sformatf("v%0d_ctl", i), {29'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en},
          {29'd0, vecs[i].wb, vecs[i].mr, vecs[i].mw});
      @(negedge clk);
    end

    // Freeze: load a known value, then hold for three cycles of changing input.
    v = '{EXE_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'h1, 32'h7, 4'h3, 32'h2, 4'b0000};
    drive(v);
    @(posedge clk);
    #1;
    chk("frz_pre_res", bus.alu_res, 32'h2);
    chk("frz_pre_st", {28'd0, bus.status}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.freeze = 1'b1;
      v = '{EXE_SUB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 32'(k), 32'h9, 4'h9, 32'h0, 4'b0000};
      drive(v);
      @(posedge clk);
      #1;
      chk($sformatf("frz%0d_res", k), bus.alu_res, 32'h2);
      chk($sformatf("frz%0d_st", k), {28'd0, bus.status}, 32'd0);
      chk($sformatf("frz%0d_dest", k), {28'd0, bus.dest}, 32'h3);
      chk($sformatf("frz%0d_rm", k), bus.val_rm, 32'h7);
      chk($sformatf("frz%0d_ctl", k), {29'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'h4);
    end
    @(negedge clk);
    bus.freeze = 1'b0;
    v = '{EXE_MVN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 4'h5, 32'hFFFFFFFF, 4'b1000};
    drive(v);
    @(posedge clk);
    #1;
    chk("unfrz_res", bus.alu_res, 32'hFFFFFFFF);
    chk("unfrz_st", {28'd0, bus.status}, 32'h8);
    chk("unfrz_dest", {28'd0, bus.dest}, 32'h5);

    // Branch target is combinational, with 32-bit wrap-around.
    @(negedge clk);
    bus.b_in = 1'b1;
    bus.pc_in = 32'h100;
    bus.signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("br_addr_neg", bus.branch_addr, 32'h000000F8);
    chk("br_taken", {31'd0, bus.branch_taken}, 32'd1);
    bus.pc_in = 32'hFFFFFFFC;
    bus.signed_imm_24_in = 24'h000001;
    #1;
    chk("br_addr_wrap", bus.branch_addr, 32'h0);
    bus.b_in = 1'b0;
    #1;
    chk("br_not_taken", {31'd0, bus.branch_taken}, 32'd0);

    // Asynchronous reset mid-cycle, with freeze asserted, clears everything.
    @(posedge clk);
    #2;
    bus.freeze = 1'b1;
    rst = 1'b1;
    #1;
    chk_outs_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.freeze = 1'b0;

`ifdef EXE_FORWARDING_EN
    // Forwarded operand A from MEM and forwarded Rm from WB.
    v = '{EXE_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'h0, 32'h0, 4'h6, 32'h11, 4'b0000};
    drive(v);
    bus.sel_src1 = FWD_MEM;
    bus.mem_fwd_val = 32'h10;
    @(posedge clk);
    #1;
    chk("fwd_mem_res", bus.alu_res, 32'h11);
    @(negedge clk);
    v = '{EXE_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h3, 4'h7, 32'hAB, 4'b0000};
    drive(v);
    bus.sel_src1 = FWD_ID;
    bus.sel_src2 = FWD_WB;
    bus.wb_fwd_val = 32'hAB;
    @(posedge clk);
    #1;
    chk("fwd_wb_res", bus.alu_res, 32'hAB);
    chk("fwd_wb_rm", bus.val_rm, 32'hAB);
    @(negedge clk);
    bus.sel_src2 = FWD_ID;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
